// File: rtl/loc_sequencer_pkg.sv
// Shared definitions for the localization sequencer: state encoding,
// default timing constants and datapath/counter widths.
package loc_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_FFT     = 3'd2,
        S_DETECT  = 3'd3,
        S_WEIGHT  = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam int STRETCH_CYC_DEF = 16;
    localparam int TIMEOUT_CYC_DEF = 2097152;
    localparam int DOA_W           = 8;
    localparam int STRETCH_W       = 5;
    localparam int TIMEOUT_W       = 22;
    localparam int FRAME_CNT_W     = 16;

endpackage

// File: rtl/loc_sequencer_if.sv
// Control/status bundle between the HPS-side controller and the
// localization sequencer.
//   master : HPS/test side, drives requests and stage-done pulses
//   slave  : sequencer side, drives capture/FFT starts and status
interface loc_sequencer_if;
    import loc_sequencer_pkg::*;

    logic                   start;
    logic                   continuous;
    logic                   abort;
    logic                   irq_clr;
    logic                   frame_ready;
    logic                   fftdone;
    logic                   detectdone;
    logic                   weightdone;
    logic [DOA_W-1:0]       doa_x_in;
    logic [DOA_W-1:0]       doa_y_in;
    logic                   capture_go;
    logic                   fft_go;
    logic                   busy;
    logic [2:0]             state_o;
    logic [DOA_W-1:0]       doa_x;
    logic [DOA_W-1:0]       doa_y;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   timeout_err;
    logic                   irq;

    modport master (
        output start, continuous, abort, irq_clr, frame_ready,
               fftdone, detectdone, weightdone, doa_x_in, doa_y_in,
        input  capture_go, fft_go, busy, state_o, doa_x, doa_y,
               frame_cnt, timeout_err, irq
    );

    modport slave (
        input  start, continuous, abort, irq_clr, frame_ready,
               fftdone, detectdone, weightdone, doa_x_in, doa_y_in,
        output capture_go, fft_go, busy, state_o, doa_x, doa_y,
               frame_cnt, timeout_err, irq
    );

endinterface

// File: rtl/loc_sequencer_pulse_stretch.sv
// pulse_stretch: loadable down-counter whose registered level output is
// high exactly while the count is nonzero. Used to hold a request long
// enough for a slower clock domain to sample it.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val into the counter
//   clear      : force the counter to zero (wins over load)
//   load_val   : stretch length in clk cycles
//   level      : registered (count != 0)
module pulse_stretch #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         level
);

    logic [W-1:0] cnt, cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clear)
            cnt_next = '0;
        else if (load)
            cnt_next = load_val;
        else if (cnt != '0)
            cnt_next = cnt - 1'b1;
    end

    // level tracks the next count so it is registered yet equal to
    // (cnt != 0) in every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            level <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/loc_sequencer.sv
// loc_sequencer: sequences one localization pass
// CAPTURE -> FFT -> DETECT -> WEIGHT -> DONE, with optional back-to-back
// passes, a per-stage timeout into ERROR, abort, and a sticky irq.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   bus        : loc_sequencer_if.slave control/status bundle
module loc_sequencer
    import loc_sequencer_pkg::*;
#(
    parameter int STRETCH_CYC = STRETCH_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    loc_sequencer_if.slave   bus
);

    state_t               state, state_next;
    logic [TIMEOUT_W-1:0] tcnt, tcnt_next;
    logic                 stretch_load, stretch_clear, stretch_active;
    logic                 waiting, timed_out;
    logic                 fft_go_r, timeout_err_r, irq_r;
    logic [DOA_W-1:0]     doa_x_r, doa_y_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;

    assign waiting   = (state == S_CAPTURE) || (state == S_FFT) ||
                       (state == S_DETECT)  || (state == S_WEIGHT);
    assign timed_out = waiting && (tcnt == TIMEOUT_W'(TIMEOUT_CYC - 1));

    pulse_stretch #(.W(STRETCH_W)) u_stretch (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (stretch_load),
        .clear    (stretch_clear),
        .load_val (STRETCH_W'(STRETCH_CYC)),
        .level    (stretch_active)
    );

    // Next state. Abort overrides everything; a timeout overrides a
    // coincident stage-done pulse. Done pulses are only looked at in the
    // state waiting for them, so strays are dropped.
    always_comb begin
        state_next   = state;
        stretch_load = 1'b0;
        if (bus.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state_next   = S_CAPTURE;
                    stretch_load = 1'b1;
                end
                S_CAPTURE: begin
                    if (timed_out)
                        state_next = S_ERROR;
                    else if (!stretch_active && bus.frame_ready)
                        state_next = S_FFT;
                end
                S_FFT: begin
                    if (timed_out)         state_next = S_ERROR;
                    else if (bus.fftdone)  state_next = S_DETECT;
                end
                S_DETECT: begin
                    if (timed_out)            state_next = S_ERROR;
                    else if (bus.detectdone)  state_next = S_WEIGHT;
                end
                S_WEIGHT: begin
                    if (timed_out)            state_next = S_ERROR;
                    else if (bus.weightdone)  state_next = S_DONE;
                end
                S_DONE: begin
                    if (bus.continuous) begin
                        state_next   = S_CAPTURE;
                        stretch_load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_ERROR: if (bus.start) begin
                    state_next   = S_CAPTURE;
                    stretch_load = 1'b1;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Stretch only survives while we stay in (or enter) CAPTURE.
    assign stretch_clear = bus.abort || (state_next != S_CAPTURE);

    always_comb begin
        tcnt_next = '0;
        if (!bus.abort && (state_next == state) && waiting)
            tcnt_next = tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            fft_go_r      <= 1'b0;
            doa_x_r       <= '0;
            doa_y_r       <= '0;
            frame_cnt_r   <= '0;
            timeout_err_r <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            state    <= state_next;
            tcnt     <= tcnt_next;
            fft_go_r <= (state_next == S_FFT) && (state != S_FFT);

            if (state == S_WEIGHT && state_next == S_DONE) begin
                doa_x_r     <= bus.doa_x_in;
                doa_y_r     <= bus.doa_y_in;
                frame_cnt_r <= frame_cnt_r + 1'b1;
            end

            if (state_next == S_ERROR && state != S_ERROR)
                timeout_err_r <= 1'b1;
            else if (state == S_ERROR && state_next == S_CAPTURE)
                timeout_err_r <= 1'b0;

            // Set beats clear so a coincident irq_clr cannot lose an event.
            if (state == S_DONE || (state_next == S_ERROR && state != S_ERROR))
                irq_r <= 1'b1;
            else if (bus.irq_clr)
                irq_r <= 1'b0;
        end
    end

    assign bus.capture_go  = stretch_active;
    assign bus.fft_go      = fft_go_r;
    assign bus.busy        = waiting;
    assign bus.state_o     = state;
    assign bus.doa_x       = doa_x_r;
    assign bus.doa_y       = doa_y_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.irq         = irq_r;

endmodule

// File: tb/tb_loc_sequencer.sv
// Directed bench for loc_sequencer: one DUT at default timing for the
// functional passes, a second with TIMEOUT_CYC=64 for the timeout path.
module tb_loc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cg_cnt = 0;
    int   fg_cnt = 0;

    always #10 clk = ~clk;

    loc_sequencer_if a();
    loc_sequencer_if t();

    loc_sequencer u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    loc_sequencer #(.STRETCH_CYC(16), .TIMEOUT_CYC(64)) u_t (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance DUT a by n cycles, tallying capture_go / fft_go high cycles.
    task automatic run(input int n);
        repeat (n) begin
            cg_cnt += int'(a.capture_go);
            fg_cnt += int'(a.fft_go);
            tick();
        end
    endtask

    // From CAPTURE cycle 0, drive one full pass ending in the DONE cycle.
    task automatic pass_body(input logic [7:0] x, input logic [7:0] y);
        run(20);
        a.frame_ready = 1'b1; run(1); a.frame_ready = 1'b0;
        run(5);
        a.fftdone = 1'b1; run(1); a.fftdone = 1'b0;
        run(3);
        a.detectdone = 1'b1; run(1); a.detectdone = 1'b0;
        run(3);
        a.doa_x_in = x; a.doa_y_in = y;
        a.weightdone = 1'b1; run(1); a.weightdone = 1'b0;
        chk("pass_done_state", 32'(a.state_o), 32'd5);
    endtask

    initial begin
        a.start = 0; a.continuous = 0; a.abort = 0; a.irq_clr = 0;
        a.frame_ready = 0; a.fftdone = 0; a.detectdone = 0; a.weightdone = 0;
        a.doa_x_in = 0; a.doa_y_in = 0;
        t.start = 0; t.continuous = 0; t.abort = 0; t.irq_clr = 0;
        t.frame_ready = 0; t.fftdone = 0; t.detectdone = 0; t.weightdone = 0;
        t.doa_x_in = 0; t.doa_y_in = 0;

        // Reset state
        #2;
        chk("rst_state", 32'(a.state_o), 32'd0);
        chk("rst_capture_go", 32'(a.capture_go), 32'd0);
        chk("rst_fft_go", 32'(a.fft_go), 32'd0);
        chk("rst_doa", {16'd0, a.doa_x, a.doa_y}, 32'd0);
        chk("rst_frame_cnt", 32'(a.frame_cnt), 32'd0);
        chk("rst_flags", {29'd0, a.timeout_err, a.irq, a.busy}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 32'(a.state_o), 32'd0);

        // Single pass
        a.start = 1'b1; run(1); a.start = 1'b0;
        chk("sp_capture", 32'(a.state_o), 32'd1);
        chk("sp_busy", 32'(a.busy), 32'd1);
        run(100);
        a.frame_ready = 1'b1; run(1); a.frame_ready = 1'b0;
        chk("sp_fft", 32'(a.state_o), 32'd2);
        chk("sp_fft_go", 32'(a.fft_go), 32'd1);
        run(49);
        a.fftdone = 1'b1; run(1); a.fftdone = 1'b0;
        chk("sp_detect", 32'(a.state_o), 32'd3);
        run(19);
        a.detectdone = 1'b1; run(1); a.detectdone = 1'b0;
        chk("sp_weight", 32'(a.state_o), 32'd4);
        a.doa_x_in = 8'h1E; a.doa_y_in = 8'hF6;
        run(19);
        a.weightdone = 1'b1; run(1); a.weightdone = 1'b0;
        chk("sp_done", 32'(a.state_o), 32'd5);
        chk("sp_doa_x", 32'(a.doa_x), 32'h1E);
        chk("sp_doa_y", 32'(a.doa_y), 32'hF6);
        chk("sp_frame_cnt", 32'(a.frame_cnt), 32'd1);
        run(1);
        chk("sp_idle", 32'(a.state_o), 32'd0);
        chk("sp_irq", 32'(a.irq), 32'd1);
        chk("sp_not_busy", 32'(a.busy), 32'd0);
        chk("sp_capture_go_cycles", 32'(cg_cnt), 32'd16);
        chk("sp_fft_go_cycles", 32'(fg_cnt), 32'd1);

        // Stray fftdone in IDLE, irq_clr, start+abort together
        a.fftdone = 1'b1; run(1); a.fftdone = 1'b0;
        run(2);
        chk("stray_fftdone_idle", 32'(a.state_o), 32'd0);
        a.irq_clr = 1'b1; run(1); a.irq_clr = 1'b0;
        chk("irq_clr", 32'(a.irq), 32'd0);
        a.start = 1'b1; a.abort = 1'b1; run(1); a.start = 1'b0; a.abort = 1'b0;
        chk("start_abort_state", 32'(a.state_o), 32'd0);
        chk("start_abort_cgo", 32'(a.capture_go), 32'd0);

        // Continuous passes from a fresh reset
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        chk("cont_rst_frame_cnt", 32'(a.frame_cnt), 32'd0);
        a.continuous = 1'b1;
        a.start = 1'b1; run(1); a.start = 1'b0;
        pass_body(8'h11, 8'h22);
        run(1);
        chk("cont_p1_recapture", 32'(a.state_o), 32'd1);
        chk("cont_p1_cgo", 32'(a.capture_go), 32'd1);
        pass_body(8'h33, 8'h44);
        run(1);
        chk("cont_p2_recapture", 32'(a.state_o), 32'd1);
        chk("cont_p2_cgo", 32'(a.capture_go), 32'd1);
        a.irq_clr = 1'b1; run(1); a.irq_clr = 1'b0;
        chk("cont_irq_cleared", 32'(a.irq), 32'd0);
        a.continuous = 1'b0;
        pass_body(8'hA5, 8'h5A);
        a.irq_clr = 1'b1; run(1); a.irq_clr = 1'b0;
        chk("irq_clr_vs_done", 32'(a.irq), 32'd1);
        chk("cont_p3_idle", 32'(a.state_o), 32'd0);
        chk("cont_frame_cnt", 32'(a.frame_cnt), 32'd3);
        chk("cont_doa_x", 32'(a.doa_x), 32'hA5);
        a.irq_clr = 1'b1; run(1); a.irq_clr = 1'b0;
        chk("irq_clr_after", 32'(a.irq), 32'd0);

        // start while busy ignored, abort in DETECT
        a.start = 1'b1; run(1); a.start = 1'b0;
        run(20);
        a.start = 1'b1; run(1); a.start = 1'b0;
        chk("busy_start_state", 32'(a.state_o), 32'd1);
        chk("busy_start_cgo", 32'(a.capture_go), 32'd0);
        a.frame_ready = 1'b1; run(1); a.frame_ready = 1'b0;
        a.fftdone = 1'b1; run(1); a.fftdone = 1'b0;
        chk("ab_detect", 32'(a.state_o), 32'd3);
        a.doa_x_in = 8'h77; a.doa_y_in = 8'h88;
        a.abort = 1'b1; run(1); a.abort = 1'b0;
        chk("ab_idle", 32'(a.state_o), 32'd0);
        chk("ab_doa", {16'd0, a.doa_x, a.doa_y}, 32'hA55A);
        chk("ab_frame_cnt", 32'(a.frame_cnt), 32'd3);
        a.weightdone = 1'b1; run(1); a.weightdone = 1'b0;
        chk("stray_weightdone", 32'(a.frame_cnt), 32'd3);

        // Reset mid-pass in WEIGHT
        a.start = 1'b1; run(1); a.start = 1'b0;
        run(20);
        a.frame_ready = 1'b1; run(1); a.frame_ready = 1'b0;
        a.fftdone = 1'b1; run(1); a.fftdone = 1'b0;
        a.detectdone = 1'b1; run(1); a.detectdone = 1'b0;
        chk("mr_weight", 32'(a.state_o), 32'd4);
        rst_n = 1'b0; #1;
        chk("mr_state", 32'(a.state_o), 32'd0);
        chk("mr_frame_cnt", 32'(a.frame_cnt), 32'd0);
        chk("mr_doa", {16'd0, a.doa_x, a.doa_y}, 32'd0);
        chk("mr_flags", {29'd0, a.capture_go, a.fft_go, a.busy}, 32'd0);
        rst_n = 1'b1;
        a.weightdone = 1'b1; run(1); a.weightdone = 1'b0;
        chk("mr_no_incr", 32'(a.frame_cnt), 32'd0);
        chk("mr_stay_idle", 32'(a.state_o), 32'd0);

        // Timeout on the short-timeout instance
        t.start = 1'b1; tick(); t.start = 1'b0;
        repeat (20) tick();
        t.frame_ready = 1'b1; tick(); t.frame_ready = 1'b0;
        chk("to_fft", 32'(t.state_o), 32'd2);
        repeat (63) tick();
        chk("to_still_fft", 32'(t.state_o), 32'd2);
        tick();
        chk("to_error", 32'(t.state_o), 32'd6);
        chk("to_err_flag", 32'(t.timeout_err), 32'd1);
        chk("to_irq", 32'(t.irq), 32'd1);
        chk("to_not_busy", 32'(t.busy), 32'd0);
        repeat (5) tick();
        chk("to_hold", 32'(t.state_o), 32'd6);
        t.start = 1'b1; tick(); t.start = 1'b0;
        chk("to_restart", 32'(t.state_o), 32'd1);
        chk("to_err_cleared", 32'(t.timeout_err), 32'd0);
        chk("to_restart_cgo", 32'(t.capture_go), 32'd1);
        t.abort = 1'b1; tick(); t.abort = 1'b0;
        chk("to_abort", 32'(t.state_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/loc_sequencer.md
LOC_SEQUENCER -- requirements
Module: loc_sequencer

Interface
REQ-001 SHALL have parameter STRETCH_CYC, default 16: clk cycles for which capture_go is held high so the SCK domain samples it.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2097152: maximum clk cycles allowed in any waiting state.
REQ-003 SHALL have ports, as name / direction / width / meaning:
- clk  in  1  50 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle HPS request to run one localization pass.
- continuous  in  1  level; when high, passes repeat back to back.
- abort  in  1  single-cycle request to return to IDLE.
- irq_clr  in  1  single-cycle request to clear irq.
- frame_ready  in  1  level; high when all eight raw-data FIFOs are full.
- fftdone  in  1  single-cycle FFT-complete pulse.
- detectdone  in  1  single-cycle frequency-detect-complete pulse.
- weightdone  in  1  single-cycle weight-block-complete pulse.
- doa_x_in  in  8  X direction of arrival (signed) from the weight block.
- doa_y_in  in  8  Y direction of arrival (signed) from the weight block.
- capture_go  out  1  stretched request to the I2S capture FSM.
- fft_go  out  1  single-cycle FFT start.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- state_o  out  3  encoded current state.
- doa_x  out  8  latched X result.
- doa_y  out  8  latched Y result.
- frame_cnt  out  16  count of completed passes.
- timeout_err  out  1  sticky; high after any stage times out.
- irq  out  1  sticky interrupt.

Function
REQ-004 SHALL implement states IDLE=0, CAPTURE=1, FFT=2, DETECT=3, WEIGHT=4, DONE=5, ERROR=6.
REQ-005 IDLE: on start, SHALL go to CAPTURE, load the stretch counter with STRETCH_CYC and clear the timeout counter.
REQ-006 capture_go SHALL be high exactly while the stretch counter is nonzero, i.e. STRETCH_CYC cycles starting the cycle after entry to CAPTURE.
REQ-007 CAPTURE: frame_ready is ignored until the stretch counter reaches zero; once it is zero and frame_ready is high, SHALL go to FFT.
REQ-008 fft_go SHALL pulse for exactly one cycle, on the first cycle in FFT.
REQ-009 FFT→DETECT on fftdone; DETECT→WEIGHT on detectdone; WEIGHT→DONE on weightdone.
REQ-010 Any done pulse that arrives in a state not waiting for it SHALL be ignored and SHALL NOT be remembered.
REQ-011 On the weightdone cycle, SHALL latch doa_x_in and doa_y_in into doa_x and doa_y, and increment frame_cnt.
REQ-012 frame_cnt SHALL wrap from 0xFFFF to 0.
REQ-013 DONE lasts one cycle and SHALL set irq.
REQ-014 DONE exit: if continuous is high, go to CAPTURE (stretch reloaded, timeout counter cleared); otherwise go to IDLE.
REQ-015 The timeout counter SHALL count every cycle in CAPTURE, FFT, DETECT and WEIGHT, and SHALL be cleared on every state change.
REQ-016 When the timeout counter reaches TIMEOUT_CYC-1, SHALL go to ERROR and set timeout_err and irq.
REQ-017 ERROR SHALL hold until abort or start.
REQ-018 start in ERROR SHALL go to CAPTURE and clear timeout_err.
REQ-019 abort in any state SHALL go to IDLE next cycle and clear the stretch and timeout counters; doa_x, doa_y and frame_cnt SHALL be retained.
REQ-020 abort and start in the same cycle: abort SHALL win.
REQ-021 start while busy SHALL be ignored.
REQ-022 irq_clr SHALL clear irq; if irq_clr and an irq-setting event occur in the same cycle, irq SHALL stay set.
REQ-023 All outputs SHALL be registered, except busy and state_o, which are decoded from the state register.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE and zero every output (including capture_go, fft_go, doa_x, doa_y, frame_cnt, timeout_err and irq) and both internal counters.
REQ-025 Reset deassertion SHALL take effect on the next rising edge of clk; no pass SHALL start without a new start.

Structure
REQ-026 A shared package SHALL hold the state enum (3-bit), the default STRETCH_CYC and TIMEOUT_CYC constants, and the DOA width (8).
REQ-027 The stretch logic SHALL be a sub-module pulse_stretch (load / count-down / level output), reusable for any clk-to-SCK handshake.
REQ-028 The stretch counter SHALL be 5 bits wide; the timeout counter SHALL be 22 bits wide.

Verification
REQ-029 Single pass: start; frame_ready raised 100 cycles later; fftdone +50; detectdone +20; weightdone +20 with doa 0x1E/0xF6 -> capture_go high 16 cycles, one fft_go, doa_x=0x1E, doa_y=0xF6, frame_cnt=1, irq=1, state returns to 0.
REQ-030 Continuous: continuous=1 across 3 passes -> frame_cnt=3 and capture_go reasserted after each DONE; clearing continuous during pass 3 -> IDLE after pass 3.
REQ-031 Timeout: TIMEOUT_CYC=64, start, fftdone never arrives -> ERROR exactly 64 cycles after entering FFT, timeout_err=1, irq=1; then start -> CAPTURE with timeout_err=0.
REQ-032 Abort and stray pulses: abort in DETECT -> IDLE next cycle, doa unchanged; fftdone pulsed in IDLE -> no state change; start and abort in the same cycle -> stays IDLE.
REQ-033 Reset mid-pass: rst_n low in WEIGHT -> all outputs 0 immediately, and a later weightdone does not increment frame_cnt.
REQ-034 irq_clr in the same cycle as DONE -> irq stays 1; irq_clr one cycle later -> irq=0.
